// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU (add/sub/inc/dec/and/or/xor/not) with carry, overflow, zero and negative flags.
// Latency: 2 clocks from input accept to out_valid; sustains 1 op/clock.
// Backpressure: out_ready low holds y/flags stable; up to 2 ops buffered, then in_ready drops.
//
// Ports:
//   clk, rst                    single clock; asynchronous active-high reset
//   in_valid/in_ready, a, b, op input handshake and operands (op: 000 add, 001 sub, 010 inc a,
//                               011 dec a, 100 and, 101 or, 110 xor, 111 not a)
//   out_valid/out_ready         output handshake
//   y, cout, ovf, zero, neg     result and flags (cout on sub/dec: 1 = no borrow)
// Optional build macro ALU_SAT_EN: unsigned saturation on add/sub/inc/dec
// (cout/ovf still describe the raw result).
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
    } opnd_t;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
    } res_t;

    logic             s1_valid;
    logic             s2_valid;
    opnd_t            s1_dat;
    res_t             s2_dat;
    res_t             res_nxt;
    logic             accept;
    logic             s2_load;

    logic [WIDTH-1:0] opb;
    logic             cin;
    logic             arith;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;

    // Ready only depends on pipeline occupancy and out_ready, never on in_valid.
    assign in_ready = !s1_valid || !s2_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign s2_load  = s1_valid && (!s2_valid || out_ready);

    // Stage-2 datapath: every arithmetic op is folded onto one adder as
    // a + opb + cin, so carry and overflow come out of a single sum.
    always_comb begin
        opb   = s1_dat.b;
        cin   = 1'b0;
        arith = 1'b1;
        case (s1_dat.op)
            OP_ADD: begin opb = s1_dat.b;  cin = 1'b0; end
            OP_SUB: begin opb = ~s1_dat.b; cin = 1'b1; end
            OP_INC: begin opb = '0;        cin = 1'b1; end
            OP_DEC: begin opb = '1;        cin = 1'b0; end
            default: arith = 1'b0;
        endcase

        sum     = {1'b0, s1_dat.a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        r       = '0;
        res_nxt = '0;

        if (arith) begin
            r            = sum[WIDTH-1:0];
            res_nxt.cout = sum[WIDTH];
            // Signed overflow: operands agree in sign but the result does not.
            res_nxt.ovf  = (s1_dat.a[WIDTH-1] == opb[WIDTH-1]) &&
                           (sum[WIDTH-1] != s1_dat.a[WIDTH-1]);
`ifdef ALU_SAT_EN
            // op[0]=0: add/inc (carry saturates high); op[0]=1: sub/dec (borrow saturates low).
            if (!s1_dat.op[0] && sum[WIDTH]) begin
                r = '1;
            end else if (s1_dat.op[0] && !sum[WIDTH]) begin
                r = '0;
            end
`endif
        end else begin
            case (s1_dat.op)
                OP_AND:  r = s1_dat.a & s1_dat.b;
                OP_OR:   r = s1_dat.a | s1_dat.b;
                OP_XOR:  r = s1_dat.a ^ s1_dat.b;
                default: r = ~s1_dat.a;
            endcase
        end

        res_nxt.y    = r;
        res_nxt.zero = (r == '0);
        res_nxt.neg  = r[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_dat   <= '0;
            s2_dat   <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_dat   <= '{a: a, b: b, op: op};
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_dat   <= res_nxt;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid;
    assign y         = s2_dat.y;
    assign cout      = s2_dat.cout;
    assign ovf       = s2_dat.ovf;
    assign zero      = s2_dat.zero;
    assign neg       = s2_dat.neg;

endmodule
